// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder and its lane-alignment helper.
//   size_e  : request access size encoding (byte / half / word / illegal)
//   state_e : responder FSM states
//   CntW    : width of the wait-state counter (LATENCY range 0..15)
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SzByte    = 2'b00,
        SzHalf    = 2'b01,
        SzWord    = 2'b10,
        SzIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned CntW = 4;

    // Access is illegal if the size is reserved or the address is not naturally aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        unique case (size)
            SzByte:  bad = 1'b0;
            SzHalf:  bad = addr[0];
            SzWord:  bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational little-endian byte-lane helper, shared with the datapath.
// Ports:
//   word        in  32  current contents of the addressed memory word
//   addr        in  2   byte offset within the word
//   size        in  2   00 byte, 01 half, 10 word, 11 illegal
//   sign_ext    in  1   loads: 1 sign-extend, 0 zero-extend (ignored for words)
//   wdata       in  32  store data, right-justified
//   load_ext    out 32  selected lanes right-justified and extended
//   merged_word out 32  word with the selected lanes replaced by wdata
//   misaligned  out 1   illegal size or unaligned address
module data_mem_responder_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] wdata_sh;

    always_comb begin
        shamt      = {addr, 3'b000};
        shifted    = word >> shamt;
        wdata_sh   = wdata << shamt;
        misaligned = is_misaligned(size, addr);

        load_ext  = 32'h0;
        lane_mask = 32'h0;
        unique case (size)
            SzByte: begin
                load_ext  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00ff << shamt;
            end
            SzHalf: begin
                load_ext  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_ffff << shamt;
            end
            SzWord: begin
                // Only meaningful when aligned, where the shift is zero.
                load_ext  = shifted;
                lane_mask = 32'hffff_ffff;
            end
            default: begin
                // Reserved size: no lanes selected, word passes through untouched.
                load_ext  = 32'h0;
                lane_mask = 32'h0;
            end
        endcase

        merged_word = (word & ~lane_mask) | (wdata_sh & lane_mask);
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for LB/LH/LW/SB/SH/SW traffic with programmable wait states.
// One request at a time; the response appears LATENCY+1 cycles after the accept edge
// and is held until the consumer takes it.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 store, 0 load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_signed            loads: sign-extend when set
//   req_addr              byte address
//   req_wdata             right-justified store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data; 0 for stores and errors
//   rsp_err               misaligned address or illegal size
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned    Words  = 2 ** (ADDR_W - 2);
    localparam logic [CntW-1:0] LatCnt = CntW'(LATENCY);

    state_e            state;
    logic [CntW-1:0]   cnt;

    // Request latch
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [31:0]       mem [Words];
    logic [31:0]       cur_word;
    logic [31:0]       load_ext;
    logic [31:0]       merged_word;
    logic              misaligned;
    logic              access;
    logic              mem_we;

    assign cur_word = mem[lat_addr[ADDR_W-1:2]];

    data_mem_responder_lane_align u_lane_align (
        .word        (cur_word),
        .addr        (lat_addr[1:0]),
        .size        (lat_size),
        .sign_ext    (lat_signed),
        .wdata       (lat_wdata),
        .load_ext    (load_ext),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    // The access happens on the edge that leaves WAIT; reset on that edge cancels it.
    assign access = (state == StWait) && (cnt == '0);
    assign mem_we = access && !reset && lat_write && !misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        cnt        <= LatCnt;
                        req_ready  <= 1'b0;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    if (cnt == '0) begin
                        rsp_rdata <= (lat_write || misaligned) ? 32'h0 : load_ext;
                        rsp_err   <= misaligned;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StResp: begin
                    // rdata/err deliberately held after the handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_addr[ADDR_W-1:2]] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (ADDR_W=8, LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    data_mem_responder #(
        .ADDR_W  (8),
        .LATENCY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; inputs driven and outputs sampled on negedges.
    task automatic xfer(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        logic [31:0] held;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hA5A5_A5A5;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd3);
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata, held);
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " done valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " done req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " rdata held"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 8'h10;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        // Reset with a request pending: nothing may be accepted.
        repeat (2) begin
            @(negedge clk);
            check("reset req_ready", 32'(req_ready), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid), 32'd0);
            check("reset rdata", rsp_rdata, 32'h0);
            check("reset err", 32'(rsp_err), 32'd0);
        end
        req_valid = 1'b0;
        reset     = 1'b0;
        repeat (4) @(negedge clk);
        check("post-reset no accept", 32'(rsp_valid), 32'd0);
        check("post-reset ready", 32'(req_ready), 32'd1);

        xfer("SW 10", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xfer("LW 10", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        xfer("SB 11", 1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFF_FF80, 32'h0, 1'b0, 0);
        xfer("LB 11", 1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
        xfer("LBU 11", 1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 32'h0000_0080, 1'b0, 0);
        xfer("LW 10 b", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEAD_80EF, 1'b0, 0);

        xfer("SH 12", 1'b1, 2'b01, 1'b0, 8'h12, 32'hABCD_1234, 32'h0, 1'b0, 0);
        xfer("LH 12", 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 32'h0000_1234, 1'b0, 0);
        xfer("LW 10 c", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h1234_80EF, 1'b0, 0);
        xfer("LH 10 s", 1'b0, 2'b01, 1'b1, 8'h10, 32'h0, 32'hFFFF_80EF, 1'b0, 0);
        xfer("LBU 13", 1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 32'h0000_0012, 1'b0, 0);
        xfer("LW word-ignores-signed", 1'b0, 2'b10, 1'b1, 8'h10, 32'h0, 32'h1234_80EF,
             1'b0, 0);

        // Error cases: no access, rdata 0, memory untouched.
        xfer("LH 11 err", 1'b0, 2'b01, 1'b1, 8'h11, 32'h0, 32'h0, 1'b1, 0);
        xfer("SW 12 err", 1'b1, 2'b10, 1'b0, 8'h12, 32'h0000_0000, 32'h0, 1'b1, 0);
        xfer("SH 13 err", 1'b1, 2'b01, 1'b0, 8'h13, 32'h0000_0000, 32'h0, 1'b1, 0);
        xfer("S size11 err", 1'b1, 2'b11, 1'b0, 8'h10, 32'h0000_0000, 32'h0, 1'b1, 0);
        xfer("LW after err", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h1234_80EF, 1'b0, 0);

        // Consumer stall in RESP.
        xfer("LW stall", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h1234_80EF, 1'b0, 5);

        // Reset while a store waits: the store must be abandoned.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 8'h10;
        req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid-wait req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort rdata", rsp_rdata, 32'h0);
        repeat (4) @(negedge clk);
        check("abort no rsp", 32'(rsp_valid), 32'd0);
        xfer("LW after abort", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h1234_80EF, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
